// File: rtl/out_port_fifo.sv
// Strobe-edge-triggered output FIFO with per-entry channel tag; optional per-channel latch under OUT_PORT_LATCH_EN.
// Latency: push on strobe edge at N is visible at N+1; pop at N shows next head at N+1.
// Backpressure: head held stable until out_ready; writes to a full FIFO without a same-cycle pop are dropped and set sticky overflow.
module out_port_fifo #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int CH_BITS = 2
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       BusMuxOut,
    input  logic                   OutPortIn,
    input  logic [CH_BITS-1:0]     ch_sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [CH_BITS-1:0]     out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
`ifdef OUT_PORT_LATCH_EN
    ,
    output logic [(2**CH_BITS)*WIDTH-1:0] ch_latch
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [CH_BITS-1:0] ch;
        logic [WIDTH-1:0]   dat;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            strobe_q, strobe_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, accept;

    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign overflow  = overflow_q;
    assign out_data  = mem_q[rd_ptr_q].dat;
    assign out_ch    = mem_q[rd_ptr_q].ch;

    always_comb begin
        push       = OutPortIn & ~strobe_q;
        pop        = out_valid & out_ready;
        // A full FIFO still takes the write when the head retires in the same cycle.
        accept     = push & (~full | pop);
        strobe_d   = OutPortIn;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push & ~accept);
        mem_d      = mem_q;
        if (accept) begin
            mem_d[wr_ptr_q] = '{ch: ch_sel, dat: BusMuxOut};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            strobe_q   <= strobe_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef OUT_PORT_LATCH_EN
    localparam int NCH = 2**CH_BITS;

    logic [NCH-1:0][WIDTH-1:0] latch_q, latch_d;

    always_comb begin
        latch_d = latch_q;
        if (push) begin
            latch_d[ch_sel] = BusMuxOut;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign ch_latch = latch_q;
`endif
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo: reset, edge-detect, overflow, full push+pop, back-to-back, mid-run reset, channel latch.
module tb_out_port_fifo;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int CH_BITS = 2;

    logic                   clk = 1'b0;
    logic                   clr = 1'b1;
    logic [WIDTH-1:0]       BusMuxOut = '0;
    logic                   OutPortIn = 1'b0;
    logic [CH_BITS-1:0]     ch_sel = '0;
    logic [WIDTH-1:0]       out_data;
    logic [CH_BITS-1:0]     out_ch;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
`ifdef OUT_PORT_LATCH_EN
    logic [(2**CH_BITS)*WIDTH-1:0] ch_latch;
`endif

    int total = 0;
    int bad   = 0;

    out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH_BITS(CH_BITS)) dut (
        .clk       (clk),
        .clr       (clr),
        .BusMuxOut (BusMuxOut),
        .OutPortIn (OutPortIn),
        .ch_sel    (ch_sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
`ifdef OUT_PORT_LATCH_EN
        ,
        .ch_latch  (ch_latch)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge and settle, so outputs are read away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d, input logic [CH_BITS-1:0] c);
        BusMuxOut = d;
        ch_sel    = c;
        OutPortIn = 1'b1;
        step();
        OutPortIn = 1'b0;
        step();
    endtask

    task automatic test_reset();
        OutPortIn = 1'b0;
        do_reset();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    endtask

    task automatic test_hold_strobe();
        out_ready = 1'b0;
        BusMuxOut = 32'h55;
        ch_sel    = 2'd2;
        OutPortIn = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_no_bypass got=%b exp=0", out_valid); end
        step();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL hold_count1 got=%0d exp=1", count); end
        total++; if (out_data !== 32'h55) begin bad++; $display("FAIL hold_data got=%h exp=00000055", out_data); end
        total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL hold_ch got=%0d exp=2", out_ch); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 4; i++) step();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL hold_count_after5 got=%0d exp=1", count); end
        OutPortIn = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL hold_drained got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) do_push(WIDTH'(i), 2'd0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (out_data !== WIDTH'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, out_data, WIDTH'(i)); end
            step();
        end
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b exp=1", empty); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] exp;
        do_reset();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf_cleared got=%b exp=0", overflow); end
        for (int i = 0; i < 8; i++) do_push(32'h10 + WIDTH'(i), 2'd1);
        BusMuxOut = 32'hAA;
        ch_sel    = 2'd3;
        OutPortIn = 1'b1;
        out_ready = 1'b1;
        step();
        OutPortIn = 1'b0;
        out_ready = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? (32'h11 + WIDTH'(i)) : 32'hAA;
            total++; if (out_data !== exp) begin bad++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, out_data, exp); end
            step();
        end
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        do_push(32'hA0, 2'd0);
        do_push(32'hB0, 2'd1);
        BusMuxOut = 32'hC0;
        ch_sel    = 2'd2;
        OutPortIn = 1'b1;
        out_ready = 1'b1;
        step();
        OutPortIn = 1'b0;
        out_ready = 1'b0;
        total++; if (count !== 4'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
        total++; if (out_data !== 32'hB0) begin bad++; $display("FAIL b2b_head got=%h exp=000000b0", out_data); end
        step();
        total++; if (out_data !== 32'hB0) begin bad++; $display("FAIL b2b_stable got=%h exp=000000b0", out_data); end
        total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL b2b_stable_ch got=%0d exp=1", out_ch); end
        out_ready = 1'b1;
        step();
        total++; if (out_data !== 32'hC0) begin bad++; $display("FAIL b2b_next got=%h exp=000000c0", out_data); end
        step();
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) do_push(32'h40 + WIDTH'(i), 2'd0);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL rmid_pre got=%0d exp=3", count); end
        BusMuxOut = 32'h77;
        ch_sel    = 2'd1;
        OutPortIn = 1'b1;
        clr       = 1'b1;
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rmid_during got=%0d exp=0", count); end
        step();
        clr = 1'b0;
        step();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL rmid_after got=%0d exp=1", count); end
        total++; if (out_data !== 32'h77) begin bad++; $display("FAIL rmid_data got=%h exp=00000077", out_data); end
        OutPortIn = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

`ifdef OUT_PORT_LATCH_EN
    task automatic test_latch();
        do_reset();
        do_push(32'h12, 2'd1);
        do_push(32'h34, 2'd3);
        total++; if (ch_latch[1*WIDTH +: WIDTH] !== 32'h12) begin bad++; $display("FAIL latch_ch1 got=%h exp=00000012", ch_latch[1*WIDTH +: WIDTH]); end
        total++; if (ch_latch[3*WIDTH +: WIDTH] !== 32'h34) begin bad++; $display("FAIL latch_ch3 got=%h exp=00000034", ch_latch[3*WIDTH +: WIDTH]); end
        total++; if (ch_latch[0*WIDTH +: WIDTH] !== 32'h0) begin bad++; $display("FAIL latch_ch0 got=%h exp=0", ch_latch[0*WIDTH +: WIDTH]); end
        total++; if (ch_latch[2*WIDTH +: WIDTH] !== 32'h0) begin bad++; $display("FAIL latch_ch2 got=%h exp=0", ch_latch[2*WIDTH +: WIDTH]); end
    endtask
`endif

    initial begin
        test_reset();
        test_hold_strobe();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
`ifdef OUT_PORT_LATCH_EN
        test_latch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
